// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM state type and counter sizing for the EX-stage mul/div unit.
// The divider is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } muldiv_state_e;

    // Step counter must hold values up to WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on a 2*WIDTH register.
// The restoring-divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    // Upper half accumulates the product; lower half shifts out multiplier bits.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Upper half is the partial remainder; quotient bits enter at the bottom.
    always_comb begin
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, b_q};
        if (diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end
`else
    assign div_next = mul_next;
`endif

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            acc_d = is_div_i ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit writing HI/LO and stalling the front end.
// DIV/DIVU are supported only when MULDIV_DIV_EN is defined; otherwise they are ignored.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = cnt_width(WIDTH);
`ifdef MULDIV_DIV_EN
    localparam logic DivEn = 1'b1;
`else
    localparam logic DivEn = 1'b0;
`endif

    muldiv_state_e      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               rs_neg_q, rs_neg_d;
    logic               rt_neg_q, rt_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        is_signed = ~op[0];
        rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        accept    = start & ~flush & (DivEn | ~op[1]);
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (load),
        .step_i   (state_q == StCalc),
        .is_div_i (op_q[1]),
        .a_i      (rs_mag),
        .b_i      (rt_mag),
        .acc_o    (acc)
    );

    // Sign correction applied to the unsigned datapath result during FIX.
    always_comb begin
        prod = acc;
        if (op_q == OP_MULT && (rs_neg_q ^ rt_neg_q)) begin
            prod = -acc;
        end
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (op_q == OP_DIV) begin
            if (rs_neg_q ^ rt_neg_q) quot = -acc[WIDTH-1:0];
            if (rs_neg_q)            rem  = -acc[2*WIDTH-1:WIDTH];
        end
        // Divide by zero leaves the dividend as remainder; only LO needs forcing.
        if (dz_q) quot = '1;
        if (op_q[1]) begin
            fix_hi = rem;
            fix_lo = quot;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rs_neg_d = rs_neg_q;
        rt_neg_d = rt_neg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    op_d     = op;
                    rs_neg_d = is_signed & rs_val[WIDTH-1];
                    rt_neg_d = is_signed & rt_val[WIDTH-1];
                    dz_d     = op[1] & (rt_val == '0);
                    load     = 1'b1;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                state_d = StDone;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            rs_neg_q <= 1'b0;
            rt_neg_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rs_neg_q <= rs_neg_d;
            rt_neg_q <= rt_neg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // reset_n gate keeps stall low while start is high during reset.
    assign stall       = reset_n & (((state_q == StIdle) & accept) | (state_q == StCalc) |
                                    (state_q == StFix));
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign div_by_zero = DivEn & dz_q & (state_q == StDone);
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the operands and decoded op held in the ID/EX pipeline register. It computes MULT/MULTU/DIV/DIVU into HI/LO over multiple cycles. While it works, it asserts `stall` to freeze PC, IF/ID and ID/EX.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`  in  1  pipeline clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  ID/EX holds a mul/div instruction. Sampled only in IDLE.
- `op`  in  2  ID/EX mul/div opcode: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  WIDTH  Rs operand after forwarding; multiplicand or dividend.
- `rt_val`  in  WIDTH  Rt operand after forwarding; multiplier or divisor.
- `flush`  in  1  abort the in-flight operation (branch or exception flush).
- `stall`  out  1  freeze request to PC, IF/ID and ID/EX. Combinational.
- `busy`  out  1  high when the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; new HI/LO are valid in this same cycle.
- `div_by_zero`  out  1  pulses together with `done` on DIV/DIVU with `rt_val`==0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers, read by MFHI/MFLO.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC when `start` and not `flush`. On that edge the unit:
  - latches `op` and the operand signs;
  - latches the operand magnitudes (absolute value for MULT/DIV, raw value for MULTU/DIVU);
  - clears the step counter.
- CALC: one step per cycle for exactly `WIDTH` cycles, then -> FIX.
  - MUL: shift-add on a 2*WIDTH accumulator.
  - DIV: restoring division on a 2*WIDTH remainder/quotient register.
- FIX (one cycle): sign correction. On the exit edge it writes `hi`/`lo` and -> DONE.
  - Product is negated if the signs differ (MULT only).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign (DIV only).
- DONE (one cycle): `done`=1 -> IDLE. `start` is ignored in DONE, because the ID/EX register still holds the same instruction.
- Divide by zero:
  - `lo`=all ones, `hi`=`rs_val`, `div_by_zero`=1 with `done`.
  - The unit still takes the full latency.
- Signed overflow (most-negative / -1): `lo`=0x80000000, `hi`=0 (for WIDTH=32).
- `flush` in any state: next edge -> IDLE. No `hi`/`lo` write, no `done`. When `flush` and `start` are high together in IDLE, `flush` wins.
- `stall` = (IDLE & `start` & ~`flush`) | CALC | FIX. It is low in DONE, so ID/EX loads the next instruction at the end of DONE.
- MFHI/MFLO behind an in-flight op never read stale values: ID is frozen by `stall`.

## Timing
- All outputs are 0 while `reset_n` is low, including `stall`, which is forced to 0.
- `reset_n` low mid-operation clears the FSM, counter, `hi` and `lo` immediately (asynchronous reset).
- Latency for WIDTH=32, with `start` first high in cycle 0 (IDLE):
  - CALC occupies cycles 1-32 and FIX occupies cycle 33.
  - DONE is cycle 34, and `hi`/`lo` hold the new values from cycle 34 on.
- `stall` is high in cycles 0-33, i.e. `WIDTH`+2 cycles.
- Back-to-back: a second mul/div op arriving in ID/EX starts from IDLE in cycle 35.
- `hi`/`lo` change only on the FIX->DONE edge or on reset.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops are supported.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath is removed.
  - `start` with `op`[1]=1 is ignored: no `stall`, no `done`, `hi`/`lo` unchanged.
  - `div_by_zero` is tied to 0.

## Structure
- `muldiv_pkg` holds:
  - the `op` encoding localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state typedef;
  - the step counter width, $clog2(WIDTH+1).
- One sub-module, `muldiv_iter`, contains the 2*WIDTH shift register and the add/subtract step, selected by mul/div. The FSM, sign fix and HI/LO registers stay in `ex_muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` in cycle 34; `stall` high for exactly 34 cycles.
- MULT -3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIVU 100/7 -> `lo`=14, `hi`=2.
- DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV 5/0 -> `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 with `done`, latency unchanged.
- `flush` in CALC cycle 10 -> IDLE on the next cycle, `stall` low, no `done`, `hi`/`lo` unchanged. `reset_n` low mid-CALC -> all outputs 0 immediately.
- MULTU then DIVU back-to-back -> second start in cycle 35, both results correct. Build without `MULDIV_DIV_EN`: DIV start -> `stall` never high, `hi`/`lo` unchanged.
